axi_sram_arbiter: RTL and testbench

//  2:1 AXI-Lite arbiter sharing one axi_sram_controller port between two requesters (e.g. pixel

---
 rtl/axi_sram_arbiter_pkg.sv | 23 ++
 rtl/axi_sram_arbiter_rr.sv | 32 +++
 rtl/axi_sram_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_axi_sram_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sram_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | axi_sram_arbiter_pkg : shared types/constants for the 2:1 AXI-Lite arbiter|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package axi_sram_arbiter_pkg;

  localparam logic [1:0] C_RESP_OKAY   = 2'b00;
  localparam logic [1:0] C_RESP_SLVERR = 2'b10;
  localparam int         C_STRB_WIDTH  = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/axi_sram_arbiter_rr.sv
// +--------------------------------------------------------------------------+
// | axi_sram_arbiter_rr : two-way round-robin picker owning the rr pointer   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module axi_sram_arbiter_rr (
  input  logic       axi_aclk,
  input  logic       axi_aresetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant,
  output logic       valid
);

  logic r_ptr;

  assign valid = |req;
  // On contention the pointer decides; otherwise the lone requester wins.
  assign grant = (&req) ? r_ptr : req[1];

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_ptr <= 1'b0;
    end else if (advance && valid) begin
      r_ptr <= ~grant;
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_sram_arbiter.sv
// +--------------------------------------------------------------------------+
// | axi_sram_arbiter : 2:1 AXI-Lite arbiter in front of the SRAM controller  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module axi_sram_arbiter
  import axi_sram_arbiter_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16
) (
  input  logic                      axi_aclk,
  input  logic                      axi_aresetn,
  // requester 0
  input  logic [AXI_ADDR_WIDTH-1:0] s0_axi_awaddr,
  input  logic                      s0_axi_awvalid,
  output logic                      s0_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s0_axi_wdata,
  input  logic [C_STRB_WIDTH-1:0]   s0_axi_wstrb,
  input  logic                      s0_axi_wvalid,
  output logic                      s0_axi_wready,
  output logic [1:0]                s0_axi_bresp,
  output logic                      s0_axi_bvalid,
  input  logic                      s0_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic                      s0_axi_arvalid,
  output logic                      s0_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s0_axi_rdata,
  output logic [1:0]                s0_axi_rresp,
  output logic                      s0_axi_rvalid,
  input  logic                      s0_axi_rready,
  // requester 1
  input  logic [AXI_ADDR_WIDTH-1:0] s1_axi_awaddr,
  input  logic                      s1_axi_awvalid,
  output logic                      s1_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s1_axi_wdata,
  input  logic [C_STRB_WIDTH-1:0]   s1_axi_wstrb,
  input  logic                      s1_axi_wvalid,
  output logic                      s1_axi_wready,
  output logic [1:0]                s1_axi_bresp,
  output logic                      s1_axi_bvalid,
  input  logic                      s1_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic                      s1_axi_arvalid,
  output logic                      s1_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s1_axi_rdata,
  output logic [1:0]                s1_axi_rresp,
  output logic                      s1_axi_rvalid,
  input  logic                      s1_axi_rready,
  // shared port towards the SRAM controller
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [C_STRB_WIDTH-1:0]   m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic                      arb_busy,
  output logic                      arb_grant
);

  arb_state_e r_state, w_state_nxt;
  logic       r_grant, w_grant_nxt;
  logic       r_aw_done, w_aw_done_nxt;
  logic       r_w_done, w_w_done_nxt;

  logic [1:0] w_req;
  logic [1:0] w_wreq;
  logic       w_arb_grant, w_arb_valid;
  logic       w_in_idle, w_in_wr_req, w_in_wr_resp, w_in_rd_addr, w_in_rd_data;
  logic       w_aw_hs, w_w_hs;
  logic       w_awready, w_wready, w_bvalid, w_arready, w_rvalid;

  logic [AXI_ADDR_WIDTH-1:0] w_g_awaddr, w_g_araddr;
  logic [AXI_DATA_WIDTH-1:0] w_g_wdata;
  logic [C_STRB_WIDTH-1:0]   w_g_wstrb;
  logic w_g_awvalid, w_g_wvalid, w_g_bready, w_g_arvalid, w_g_rready;

  // A write needs both AW and W presented; it outranks a read from the same side.
  assign w_wreq = {s1_axi_awvalid & s1_axi_wvalid, s0_axi_awvalid & s0_axi_wvalid};
  assign w_req  = {s1_axi_arvalid | w_wreq[1], s0_axi_arvalid | w_wreq[0]};

  axi_sram_arbiter_rr u_rr (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .req         (w_req),
    .advance     (w_in_idle),
    .grant       (w_arb_grant),
    .valid       (w_arb_valid)
  );

  assign w_in_idle    = (r_state == ST_IDLE);
  assign w_in_wr_req  = (r_state == ST_WR_REQ);
  assign w_in_wr_resp = (r_state == ST_WR_RESP);
  assign w_in_rd_addr = (r_state == ST_RD_ADDR);
  assign w_in_rd_data = (r_state == ST_RD_DATA);

  assign w_g_awaddr  = r_grant ? s1_axi_awaddr  : s0_axi_awaddr;
  assign w_g_awvalid = r_grant ? s1_axi_awvalid : s0_axi_awvalid;
  assign w_g_wdata   = r_grant ? s1_axi_wdata   : s0_axi_wdata;
  assign w_g_wstrb   = r_grant ? s1_axi_wstrb   : s0_axi_wstrb;
  assign w_g_wvalid  = r_grant ? s1_axi_wvalid  : s0_axi_wvalid;
  assign w_g_bready  = r_grant ? s1_axi_bready  : s0_axi_bready;
  assign w_g_araddr  = r_grant ? s1_axi_araddr  : s0_axi_araddr;
  assign w_g_arvalid = r_grant ? s1_axi_arvalid : s0_axi_arvalid;
  assign w_g_rready  = r_grant ? s1_axi_rready  : s0_axi_rready;

  assign m_axi_awaddr  = w_g_awaddr;
  assign m_axi_wdata   = w_g_wdata;
  assign m_axi_wstrb   = w_g_wstrb;
  assign m_axi_araddr  = w_g_araddr;
  // An accepted AW or W is masked so it is never presented twice.
  assign m_axi_awvalid = w_in_wr_req & ~r_aw_done & w_g_awvalid;
  assign m_axi_wvalid  = w_in_wr_req & ~r_w_done & w_g_wvalid;
  assign m_axi_bready  = w_in_wr_resp & w_g_bready;
  assign m_axi_arvalid = w_in_rd_addr & w_g_arvalid;
  assign m_axi_rready  = w_in_rd_data & w_g_rready;

  assign w_awready = w_in_wr_req & ~r_aw_done & m_axi_awready;
  assign w_wready  = w_in_wr_req & ~r_w_done & m_axi_wready;
  assign w_bvalid  = w_in_wr_resp & m_axi_bvalid;
  assign w_arready = w_in_rd_addr & m_axi_arready;
  assign w_rvalid  = w_in_rd_data & m_axi_rvalid;

  assign s0_axi_awready = w_awready & ~r_grant;
  assign s0_axi_wready  = w_wready  & ~r_grant;
  assign s0_axi_bvalid  = w_bvalid  & ~r_grant;
  assign s0_axi_arready = w_arready & ~r_grant;
  assign s0_axi_rvalid  = w_rvalid  & ~r_grant;
  assign s1_axi_awready = w_awready &  r_grant;
  assign s1_axi_wready  = w_wready  &  r_grant;
  assign s1_axi_bvalid  = w_bvalid  &  r_grant;
  assign s1_axi_arready = w_arready &  r_grant;
  assign s1_axi_rvalid  = w_rvalid  &  r_grant;

  assign s0_axi_bresp = m_axi_bresp;
  assign s1_axi_bresp = m_axi_bresp;
  assign s0_axi_rdata = m_axi_rdata;
  assign s1_axi_rdata = m_axi_rdata;
  assign s0_axi_rresp = m_axi_rresp;
  assign s1_axi_rresp = m_axi_rresp;

  assign w_aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_w_hs  = m_axi_wvalid & m_axi_wready;

  assign arb_busy  = ~w_in_idle;
  assign arb_grant = r_grant;

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) begin
          w_grant_nxt   = w_arb_grant;
          w_state_nxt   = w_wreq[w_arb_grant] ? ST_WR_REQ : ST_RD_ADDR;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end
      end
      ST_WR_REQ: begin
        if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
          w_state_nxt   = ST_WR_RESP;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end else begin
          w_aw_done_nxt = r_aw_done | w_aw_hs;
          w_w_done_nxt  = r_w_done | w_w_hs;
        end
      end
      ST_WR_RESP: if (m_axi_bvalid && m_axi_bready) w_state_nxt = ST_IDLE;
      ST_RD_ADDR: if (m_axi_arvalid && m_axi_arready) w_state_nxt = ST_RD_DATA;
      ST_RD_DATA: if (m_axi_rvalid && m_axi_rready) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state   <= ST_IDLE;
      r_grant   <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_sram_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_axi_sram_arbiter : arbiter + behavioural SRAM-controller model        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_axi_sram_arbiter;
  import axi_sram_arbiter_pkg::*;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int SW = C_STRB_WIDTH;

  logic axi_aclk = 1'b0;
  logic axi_aresetn = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  logic [AW-1:0] s_awaddr [2];
  logic          s_awvalid[2];
  logic          s_awready[2];
  logic [DW-1:0] s_wdata  [2];
  logic [SW-1:0] s_wstrb  [2];
  logic          s_wvalid [2];
  logic          s_wready [2];
  logic [1:0]    s_bresp  [2];
  logic          s_bvalid [2];
  logic          s_bready [2];
  logic [AW-1:0] s_araddr [2];
  logic          s_arvalid[2];
  logic          s_arready[2];
  logic [DW-1:0] s_rdata  [2];
  logic [1:0]    s_rresp  [2];
  logic          s_rvalid [2];
  logic          s_rready [2];

  logic [AW-1:0] m_awaddr, m_araddr;
  logic          m_awvalid, m_awready, m_wvalid, m_wready;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic [1:0]    m_bresp = 2'b00;
  logic          m_bvalid = 1'b0;
  logic          m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic [DW-1:0] m_rdata = '0;
  logic [1:0]    m_rresp = 2'b00;
  logic          arb_busy, arb_grant;

  axi_sram_arbiter #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .s0_axi_awaddr(s_awaddr[0]), .s0_axi_awvalid(s_awvalid[0]), .s0_axi_awready(s_awready[0]),
    .s0_axi_wdata(s_wdata[0]), .s0_axi_wstrb(s_wstrb[0]), .s0_axi_wvalid(s_wvalid[0]),
    .s0_axi_wready(s_wready[0]), .s0_axi_bresp(s_bresp[0]), .s0_axi_bvalid(s_bvalid[0]),
    .s0_axi_bready(s_bready[0]), .s0_axi_araddr(s_araddr[0]), .s0_axi_arvalid(s_arvalid[0]),
    .s0_axi_arready(s_arready[0]), .s0_axi_rdata(s_rdata[0]), .s0_axi_rresp(s_rresp[0]),
    .s0_axi_rvalid(s_rvalid[0]), .s0_axi_rready(s_rready[0]),
    .s1_axi_awaddr(s_awaddr[1]), .s1_axi_awvalid(s_awvalid[1]), .s1_axi_awready(s_awready[1]),
    .s1_axi_wdata(s_wdata[1]), .s1_axi_wstrb(s_wstrb[1]), .s1_axi_wvalid(s_wvalid[1]),
    .s1_axi_wready(s_wready[1]), .s1_axi_bresp(s_bresp[1]), .s1_axi_bvalid(s_bvalid[1]),
    .s1_axi_bready(s_bready[1]), .s1_axi_araddr(s_araddr[1]), .s1_axi_arvalid(s_arvalid[1]),
    .s1_axi_arready(s_arready[1]), .s1_axi_rdata(s_rdata[1]), .s1_axi_rresp(s_rresp[1]),
    .s1_axi_rvalid(s_rvalid[1]), .s1_axi_rready(s_rready[1]),
    .m_axi_awaddr(m_awaddr), .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
    .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
    .m_axi_araddr(m_araddr), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
    .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
    .arb_busy(arb_busy), .arb_grant(arb_grant)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- downstream SRAM controller model ----------------
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic aw_stall = 1'b0, r_stall = 1'b0;
  logic sl_got_aw = 1'b0, sl_got_w = 1'b0, sl_rpend = 1'b0;
  logic [AW-1:0] sl_wa;
  logic [DW-1:0] sl_wd;
  int wr_count = 0, w_hs_count = 0;
  logic n_aw_hs, n_w_hs, n_b_hs, n_ar_hs, n_r_hs, n_rst;
  logic [AW-1:0] n_awaddr, n_araddr;
  logic [DW-1:0] n_wdata;

  assign m_awready = !aw_stall;
  assign m_wready  = 1'b1;
  assign m_arready = 1'b1;
  assign m_rvalid  = sl_rpend && !r_stall;

  // ---------------- transaction-level reference model ----------------
  logic md_busy = 1'b0, md_wr = 1'b0, md_resp = 1'b0, md_awd = 1'b0, md_wd = 1'b0;
  int   md_g = 0, md_last = 1;
  logic md_aw_hs, md_w_hs, md_b_hs, md_ar_hs, md_r_hs;
  logic md_req[2], md_wreq[2];

  function automatic void mdl_reset();
    md_busy = 1'b0; md_wr = 1'b0; md_resp = 1'b0; md_awd = 1'b0; md_wd = 1'b0;
    md_g = 0; md_last = 1;
  endfunction

  logic e_awv, e_wv, e_br, e_arv, e_rr;
  logic e_awr[2], e_wr[2], e_bv[2], e_arr[2], e_rv[2];
  logic [16:0] exp_ctl, act_ctl;
  logic prev_busy = 1'b0;
  logic s1_bv_seen = 1'b0, s0_rv_seen = 1'b0;
  int   glog[$];

  always @(negedge axi_aresetn) begin
    sl_got_aw = 1'b0; sl_got_w = 1'b0; sl_rpend = 1'b0; m_bvalid = 1'b0;
    mdl_reset();
  end

  always @(negedge axi_aclk) begin
    n_rst    = !axi_aresetn;
    n_aw_hs  = m_awvalid && m_awready;
    n_w_hs   = m_wvalid && m_wready;
    n_b_hs   = m_bvalid && m_bready;
    n_ar_hs  = m_arvalid && m_arready;
    n_r_hs   = m_rvalid && m_rready;
    n_awaddr = m_awaddr; n_araddr = m_araddr; n_wdata = m_wdata;
    if (!axi_aresetn) mdl_reset();

    e_awv = md_busy && md_wr && !md_resp && !md_awd && s_awvalid[md_g];
    e_wv  = md_busy && md_wr && !md_resp && !md_wd && s_wvalid[md_g];
    e_br  = md_busy && md_wr && md_resp && s_bready[md_g];
    e_arv = md_busy && !md_wr && !md_resp && s_arvalid[md_g];
    e_rr  = md_busy && !md_wr && md_resp && s_rready[md_g];
    for (int n = 0; n < 2; n++) begin
      e_awr[n] = md_busy && (md_g == n) && md_wr && !md_resp && !md_awd && m_awready;
      e_wr[n]  = md_busy && (md_g == n) && md_wr && !md_resp && !md_wd && m_wready;
      e_bv[n]  = md_busy && (md_g == n) && md_wr && md_resp && m_bvalid;
      e_arr[n] = md_busy && (md_g == n) && !md_wr && !md_resp && m_arready;
      e_rv[n]  = md_busy && (md_g == n) && !md_wr && md_resp && m_rvalid;
    end
    exp_ctl = {md_busy, md_g[0], e_awv, e_wv, e_br, e_arv, e_rr,
               e_awr[0], e_wr[0], e_bv[0], e_arr[0], e_rv[0],
               e_awr[1], e_wr[1], e_bv[1], e_arr[1], e_rv[1]};
    act_ctl = {arb_busy, arb_grant, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
               s_awready[0], s_wready[0], s_bvalid[0], s_arready[0], s_rvalid[0],
               s_awready[1], s_wready[1], s_bvalid[1], s_arready[1], s_rvalid[1]};
    chk("ctl", 32'(act_ctl), 32'(exp_ctl));
    if (e_awv) chk("m_awaddr", 32'(m_awaddr), 32'(s_awaddr[md_g]));
    if (e_wv)  chk("m_wdata", 32'({m_wstrb, m_wdata}), 32'({s_wstrb[md_g], s_wdata[md_g]}));
    if (e_arv) chk("m_araddr", 32'(m_araddr), 32'(s_araddr[md_g]));
    for (int n = 0; n < 2; n++) begin
      if (e_rv[n]) chk("s_rdata", 32'({s_rresp[n], s_rdata[n]}), 32'({m_rresp, m_rdata}));
      if (e_bv[n]) chk("s_bresp", 32'(s_bresp[n]), 32'(m_bresp));
      md_wreq[n] = s_awvalid[n] && s_wvalid[n];
      md_req[n]  = s_arvalid[n] || md_wreq[n];
    end
    md_aw_hs = e_awv && m_awready;
    md_w_hs  = e_wv && m_wready;
    md_b_hs  = e_br && m_bvalid;
    md_ar_hs = e_arv && m_arready;
    md_r_hs  = e_rr && m_rvalid;

    if (arb_busy && !prev_busy) glog.push_back(int'(arb_grant) * 2 + int'(m_awvalid | m_wvalid));
    prev_busy = arb_busy;
    if (s_bvalid[1]) s1_bv_seen = 1'b1;
    if (s_rvalid[0]) s0_rv_seen = 1'b1;
  end

  always @(posedge axi_aclk) begin
    int pick;
    cyc++;
    #1;
    if (axi_aresetn && !n_rst) begin
      // SRAM controller side
      if (n_b_hs) m_bvalid = 1'b0;
      if (n_r_hs) sl_rpend = 1'b0;
      if (n_aw_hs) begin sl_got_aw = 1'b1; sl_wa = n_awaddr; end
      if (n_w_hs) begin sl_got_w = 1'b1; sl_wd = n_wdata; w_hs_count++; end
      if (sl_got_aw && sl_got_w) begin
        mem[sl_wa] = sl_wd; wr_count++;
        m_bvalid = 1'b1;
        m_bresp = sl_wa[AW-1] ? C_RESP_SLVERR : C_RESP_OKAY;
        sl_got_aw = 1'b0; sl_got_w = 1'b0;
      end
      if (n_ar_hs) begin
        sl_rpend = 1'b1;
        m_rdata = mem.exists(n_araddr) ? mem[n_araddr] : '0;
        m_rresp = C_RESP_OKAY;
      end
      // reference model: one transaction at a time, round-robin on contention
      if (!md_busy) begin
        if (md_req[0] || md_req[1]) begin
          pick = (md_req[0] && md_req[1]) ? 1 - md_last : (md_req[1] ? 1 : 0);
          md_busy = 1'b1; md_g = pick; md_last = pick; md_wr = md_wreq[pick];
          md_resp = 1'b0; md_awd = 1'b0; md_wd = 1'b0;
        end
      end else if (md_wr && !md_resp) begin
        md_awd = md_awd | md_aw_hs;
        md_wd  = md_wd | md_w_hs;
        if (md_awd && md_wd) md_resp = 1'b1;
      end else if (md_wr) begin
        if (md_b_hs) md_busy = 1'b0;
      end else if (!md_resp) begin
        if (md_ar_hs) md_resp = 1'b1;
      end else if (md_r_hs) begin
        md_busy = 1'b0;
      end
    end
  end

  // ---------------- requester drivers ----------------
  task automatic do_write(input int n, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [1:0] resp);
    logic aw_ok, w_ok, b_ok, done;
    int t;
    done = 1'b0; t = 0; resp = 2'b11;
    s_awaddr[n] = a; s_awvalid[n] = 1'b1;
    s_wdata[n] = d; s_wstrb[n] = '1; s_wvalid[n] = 1'b1; s_bready[n] = 1'b1;
    while (!done && t < 200) begin
      @(negedge axi_aclk);
      aw_ok = s_awvalid[n] && s_awready[n];
      w_ok  = s_wvalid[n] && s_wready[n];
      b_ok  = s_bvalid[n];
      if (b_ok) resp = s_bresp[n];
      @(posedge axi_aclk); #1;
      if (aw_ok) s_awvalid[n] = 1'b0;
      if (w_ok) s_wvalid[n] = 1'b0;
      if (b_ok) begin s_bready[n] = 1'b0; done = 1'b1; end
      t++;
    end
    chk("wr_done", 32'(done), 32'd1);
  endtask

  task automatic do_read(input int n, input logic [AW-1:0] a, output logic [DW-1:0] d);
    logic ar_ok, r_ok, done;
    int t;
    done = 1'b0; t = 0; d = 'x;
    s_araddr[n] = a; s_arvalid[n] = 1'b1; s_rready[n] = 1'b1;
    while (!done && t < 200) begin
      @(negedge axi_aclk);
      ar_ok = s_arvalid[n] && s_arready[n];
      r_ok  = s_rvalid[n];
      if (r_ok) d = s_rdata[n];
      @(posedge axi_aclk); #1;
      if (ar_ok) s_arvalid[n] = 1'b0;
      if (r_ok) begin s_rready[n] = 1'b0; done = 1'b1; end
      t++;
    end
    chk("rd_done", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge axi_aclk); #1;
    axi_aresetn = 1'b0;
    for (int n = 0; n < 2; n++) begin
      s_awvalid[n] = 1'b0; s_wvalid[n] = 1'b0; s_arvalid[n] = 1'b0;
      s_bready[n] = 1'b0; s_rready[n] = 1'b0;
    end
    repeat (2) @(posedge axi_aclk);
    #1 axi_aresetn = 1'b1;
    glog.delete();
  endtask

  initial begin
    logic [1:0] rsp0, rsp1;
    logic [DW-1:0] rd0, rd1;
    int c0, lat, wc0, whc0;
    for (int n = 0; n < 2; n++) begin
      s_awaddr[n] = '0; s_awvalid[n] = 1'b0; s_wdata[n] = '0; s_wstrb[n] = '0;
      s_wvalid[n] = 1'b0; s_bready[n] = 1'b0; s_araddr[n] = '0; s_arvalid[n] = 1'b0;
      s_rready[n] = 1'b0;
    end
    repeat (3) @(posedge axi_aclk);
    #1 axi_aresetn = 1'b1;
    @(negedge axi_aclk);
    chk("rst_busy", 32'(arb_busy), 32'd0);
    chk("rst_grant", 32'(arb_grant), 32'd0);

    // single write from s0; s1 idle
    @(posedge axi_aclk); #1;
    c0 = cyc; lat = -1; s1_bv_seen = 1'b0;
    fork
      do_write(0, 20'h00010, 16'hBEEF, rsp0);
      begin
        for (int k = 0; k < 20 && lat < 0; k++) begin
          @(negedge axi_aclk);
          if (m_awvalid) lat = cyc - c0;
        end
      end
    join
    chk("aw_latency", 32'(lat), 32'd1);
    chk("wr_bresp", 32'(rsp0), 32'(C_RESP_OKAY));
    chk("mem_10", 32'(mem[20'h00010]), 32'h0000BEEF);
    chk("s1_no_bvalid", 32'(s1_bv_seen), 32'd0);

    // simultaneous reads: s0 first, each gets its own data
    do_reset();
    mem[20'h00020] = 16'h5A5A;
    fork
      do_read(0, 20'h00010, rd0);
      do_read(1, 20'h00020, rd1);
    join
    chk("rd0_data", 32'(rd0), 32'h0000BEEF);
    chk("rd1_data", 32'(rd1), 32'h00005A5A);
    chk("rd_order_len", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      chk("rd_order0", 32'(glog[0]), 32'd0);
      chk("rd_order1", 32'(glog[1]), 32'd2);
    end

    // both stream 8 writes: grants strictly alternate
    do_reset();
    fork
      begin
        logic [1:0] r;
        for (int i = 0; i < 8; i++) do_write(0, 20'(32'h100 + i), 16'(32'hA000 + i), r);
      end
      begin
        logic [1:0] r;
        for (int i = 0; i < 8; i++) do_write(1, 20'(32'h200 + i), 16'(32'hB000 + i), r);
      end
    join
    chk("stream_len", 32'(glog.size()), 32'd16);
    for (int i = 0; i < glog.size() && i < 16; i++)
      chk("stream_grant", 32'(glog[i]), 32'((i % 2) * 2 + 1));
    for (int i = 0; i < 8; i++) begin
      chk("stream_mem0", 32'(mem[20'(32'h100 + i)]), 32'h0000A000 + 32'(i));
      chk("stream_mem1", 32'(mem[20'(32'h200 + i)]), 32'h0000B000 + 32'(i));
    end

    // s1 presents write and read together: write goes first
    do_reset();
    fork
      do_write(1, 20'h00040, 16'h7777, rsp1);
      do_read(1, 20'h00040, rd1);
    join
    chk("wr_before_rd_data", 32'(rd1), 32'h00007777);
    chk("wr_rd_len", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      chk("wr_rd_order0", 32'(glog[0]), 32'd3);
      chk("wr_rd_order1", 32'(glog[1]), 32'd2);
    end

    // error response passes through untouched
    do_write(1, 20'h80000, 16'h0001, rsp1);
    chk("slverr_bresp", 32'(rsp1), 32'(C_RESP_SLVERR));

    // downstream takes W before AW
    do_reset();
    aw_stall = 1'b1; wc0 = wr_count; whc0 = w_hs_count;
    fork
      do_write(0, 20'h00030, 16'h1234, rsp0);
      begin repeat (4) @(posedge axi_aclk); #1 aw_stall = 1'b0; end
    join
    chk("wfirst_writes", 32'(wr_count - wc0), 32'd1);
    chk("wfirst_whs", 32'(w_hs_count - whc0), 32'd1);
    chk("wfirst_mem", 32'(mem[20'h00030]), 32'h00001234);
    chk("wfirst_bresp", 32'(rsp0), 32'(C_RESP_OKAY));

    // reset while s0's read is waiting for data
    do_reset();
    r_stall = 1'b1;
    s_araddr[0] = 20'h00010; s_arvalid[0] = 1'b1; s_rready[0] = 1'b1;
    begin
      logic got;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge axi_aclk);
        got = s_arready[0];
        @(posedge axi_aclk); #1;
        if (got) s_arvalid[0] = 1'b0;
      end
      chk("rst_ar_accepted", 32'(got), 32'd1);
    end
    @(negedge axi_aclk);
    chk("rd_data_busy", 32'(arb_busy), 32'd1);
    @(posedge axi_aclk); #1;
    axi_aresetn = 1'b0; s_rready[0] = 1'b0;
    @(negedge axi_aclk);
    chk("midrst_busy", 32'(arb_busy), 32'd0);
    chk("midrst_outs", 32'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                            s_rvalid[0], s_rvalid[1], s_arready[0], s_arready[1]}), 32'd0);
    @(posedge axi_aclk); #1;
    axi_aresetn = 1'b1; r_stall = 1'b0; glog.delete(); s0_rv_seen = 1'b0;
    do_read(1, 20'h00020, rd1);
    chk("post_rst_rd1", 32'(rd1), 32'h00005A5A);
    chk("post_rst_grant", 32'(glog.size() > 0 ? glog[0] : -1), 32'd2);
    chk("post_rst_s0_quiet", 32'(s0_rv_seen), 32'd0);

    repeat (3) @(posedge axi_aclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
